ens_score_vote: RTL and testbench

//  Downstream consumer of the final-layer neuron LUTs of each ensemble member. Accepts one

---
 rtl/ens_vote_pkg.sv | 25 ++
 rtl/ens_score_vote_if.sv | 36 +++
 rtl/ens_argmax_scan.sv | 62 ++++++
 rtl/ens_score_vote.sv | 109 ++++++++++
 tb/tb_ens_score_vote.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ens_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module : ens_vote_pkg
// Brief  : Shared FSM state type and width helpers for the ensemble score vote.
// Rev    : 1.0  initial release
// ============================================================================
package ens_vote_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int CLS_W(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

    // Sum of NUM_MEMBERS unsigned codes cannot exceed this width.
    function automatic int ACC_W(input int score_w, input int num_members);
        return score_w + $clog2(num_members + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ens_score_vote_if.sv
`default_nettype none
// ============================================================================
// Module : ens_score_vote_if
// Brief  : Score-vector input stream and decision output stream of the vote.
// Rev    : 1.0  initial release
// ============================================================================
interface ens_score_vote_if
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = 5,
    parameter int SCORE_W     = 2,
    parameter int NUM_MEMBERS = 4
);
    localparam int C_CLS_W = CLS_W(NUM_CLASSES);
    localparam int C_ACC_W = ACC_W(SCORE_W, NUM_MEMBERS);

    logic                           s_valid;
    logic                           s_ready;
    logic [NUM_CLASSES*SCORE_W-1:0] s_scores;
    logic                           m_valid;
    logic                           m_ready;
    logic [C_CLS_W-1:0]             m_class;
    logic [C_ACC_W-1:0]             m_score;
    logic                           m_tie;

    modport master (
        output s_valid, s_scores, m_ready,
        input  s_ready, m_valid, m_class, m_score, m_tie
    );

    modport slave (
        input  s_valid, s_scores, m_ready,
        output s_ready, m_valid, m_class, m_score, m_tie
    );
endinterface
`default_nettype wire

// File: rtl/ens_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module : ens_argmax_scan
// Brief  : Sequential argmax, one class per cycle; lowest index wins ties.
// Rev    : 1.0  initial release
// ============================================================================
module ens_argmax_scan #(
    parameter int NUM_CLASSES = 5,
    parameter int ACC_W       = 5,
    parameter int CLS_W       = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [ACC_W-1:0] acc_in,
    output logic      [CLS_W-1:0] idx,
    output logic      [ACC_W-1:0] best,
    output logic      [CLS_W-1:0] best_class,
    output logic                  tie,
    output logic                  done
);
    localparam logic [CLS_W-1:0] C_LAST = CLS_W'(NUM_CLASSES - 1);

    logic r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            best       <= '0;
            best_class <= '0;
            tie        <= 1'b0;
            done       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                idx    <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (idx == '0) begin
                    best       <= acc_in;
                    best_class <= '0;
                    tie        <= 1'b0;
                end else if (acc_in > best) begin
                    best       <= acc_in;
                    best_class <= idx;
                    tie        <= 1'b0;
                end else if (acc_in == best) begin
                    tie <= 1'b1;
                end
                if (idx == C_LAST) begin
                    idx    <= '0;
                    r_busy <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    idx <= idx + CLS_W'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ens_score_vote.sv
`default_nettype none
// ============================================================================
// Module : ens_score_vote
// Brief  : Sums NUM_MEMBERS class-score vectors and emits the argmax class.
// Rev    : 1.0  initial release
// ============================================================================
module ens_score_vote
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = 5,
    parameter int SCORE_W     = 2,
    parameter int NUM_MEMBERS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ens_score_vote_if.slave    bus
);
    localparam int C_CLS_W = CLS_W(NUM_CLASSES);
    localparam int C_ACC_W = ACC_W(SCORE_W, NUM_MEMBERS);
    localparam int C_CNT_W = $clog2(NUM_MEMBERS + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_count;
    logic [C_ACC_W-1:0]   r_acc [NUM_CLASSES];
    logic                 r_m_valid;
    logic [C_CLS_W-1:0]   r_m_class;
    logic [C_ACC_W-1:0]   r_m_score;
    logic                 r_m_tie;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_release;
    logic [C_CLS_W-1:0]   w_idx;
    logic [C_ACC_W-1:0]   w_best;
    logic [C_CLS_W-1:0]   w_best_class;
    logic                 w_tie;
    logic                 w_scan_done;

    assign bus.s_ready = (r_state == ACCUM) && !rst;
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_last      = w_accept && (r_count == C_CNT_W'(NUM_MEMBERS - 1));
    assign w_release   = (r_state == DONE) && bus.m_ready;

    assign bus.m_valid = r_m_valid;
    assign bus.m_class = r_m_class;
    assign bus.m_score = r_m_score;
    assign bus.m_tie   = r_m_tie;

    // Scan starts on the edge that absorbs the final member, so idx 0 sees the full sum.
    ens_argmax_scan #(
        .NUM_CLASSES (NUM_CLASSES),
        .ACC_W       (C_ACC_W),
        .CLS_W       (C_CLS_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .start      (w_last),
        .acc_in     (r_acc[w_idx]),
        .idx        (w_idx),
        .best       (w_best),
        .best_class (w_best_class),
        .tie        (w_tie),
        .done       (w_scan_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_last)      w_state_nxt = SCAN;
            SCAN:    if (w_scan_done) w_state_nxt = DONE;
            DONE:    if (bus.m_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_m_class <= '0;
            r_m_score <= '0;
            r_m_tie   <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
        end else begin
            if (w_accept) begin
                r_count <= w_last ? '0 : r_count + C_CNT_W'(1);
                for (int c = 0; c < NUM_CLASSES; c++)
                    r_acc[c] <= r_acc[c] + C_ACC_W'(bus.s_scores[c*SCORE_W +: SCORE_W]);
            end
            if ((r_state == SCAN) && w_scan_done) begin
                r_m_valid <= 1'b1;
                r_m_class <= w_best_class;
                r_m_score <= w_best;
                r_m_tie   <= w_tie;
            end
            if (w_release) begin
                r_m_valid <= 1'b0;
                for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ens_score_vote.sv
`default_nettype none
// ============================================================================
// Module : tb_ens_score_vote
// Brief  : Directed self-checking bench for ens_score_vote (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ens_score_vote;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ens_score_vote_if #(.NUM_CLASSES(5), .SCORE_W(2), .NUM_MEMBERS(4)) bus ();

    ens_score_vote #(.NUM_CLASSES(5), .SCORE_W(2), .NUM_MEMBERS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Presents v and returns after the accepting edge; s_valid is left high.
    task automatic send_vec(input logic [9:0] v, output int acc_cyc, output bit ok);
        int n = 0;
        bus.s_valid  = 1'b1;
        bus.s_scores = v;
        while (!bus.s_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = bus.s_ready;
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(output int seen_cyc, output bit ok);
        int n = 0;
        while (!bus.m_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        ok = bus.m_valid;
        seen_cyc = cyc;
    endtask

    task automatic release_decision();
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        checks++; if (bus.m_class !== 3'd0) begin errors++; $display("FAIL reset_m_class got %0d want 0", bus.m_class); end
        checks++; if (bus.m_score !== 5'd0) begin errors++; $display("FAIL reset_m_score got %0d want 0", bus.m_score); end
        checks++; if (bus.m_tie !== 1'b0) begin errors++; $display("FAIL reset_m_tie got %b want 0", bus.m_tie); end
    endtask

    task automatic test_single_class(input string tag, input int gap);
        int a = 0, v = 0; bit ok, all_ok = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send_vec(10'h030, a, ok); all_ok &= ok;
            if (gap > 0) begin
                bus.s_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        bus.s_valid = 1'b0;
        wait_valid(v, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL %s_timeout handshake did not complete", tag); end
        checks++; if (v - a !== 6) begin errors++; $display("FAIL %s_latency got %0d want 6", tag, v - a); end
        checks++; if (bus.m_class !== 3'd2) begin errors++; $display("FAIL %s_class got %0d want 2", tag, bus.m_class); end
        checks++; if (bus.m_score !== 5'd12) begin errors++; $display("FAIL %s_score got %0d want 12", tag, bus.m_score); end
        checks++; if (bus.m_tie !== 1'b0) begin errors++; $display("FAIL %s_tie got %b want 0", tag, bus.m_tie); end
        release_decision();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL %s_release got m_valid %b want 0", tag, bus.m_valid); end
    endtask

    task automatic test_tie();
        logic [9:0] vecs [4] = '{10'h044, 10'h088, 10'h044, 10'h088};
        int a = 0, v = 0; bit ok, all_ok = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send_vec(vecs[m], a, ok); all_ok &= ok;
        end
        bus.s_valid = 1'b0;
        wait_valid(v, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL tie_timeout handshake did not complete"); end
        checks++; if (bus.m_class !== 3'd1) begin errors++; $display("FAIL tie_class got %0d want 1", bus.m_class); end
        checks++; if (bus.m_score !== 5'd6) begin errors++; $display("FAIL tie_score got %0d want 6", bus.m_score); end
        checks++; if (bus.m_tie !== 1'b1) begin errors++; $display("FAIL tie_flag got %b want 1", bus.m_tie); end
        release_decision();
    endtask

    task automatic test_backpressure();
        int a = 0, v = 0; bit ok, all_ok = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send_vec(10'h300, a, ok); all_ok &= ok;
        end
        bus.s_valid = 1'b0;
        wait_valid(v, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL hold_timeout handshake did not complete"); end
        for (int k = 0; k < 10; k++) begin
            bus.s_valid  = k[0];
            bus.s_scores = 10'h003;
            @(posedge clk); #1;
            checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cycle %0d got %b want 1", k, bus.m_valid); end
            checks++; if (bus.m_class !== 3'd4) begin errors++; $display("FAIL hold_class cycle %0d got %0d want 4", k, bus.m_class); end
            checks++; if (bus.m_score !== 5'd12) begin errors++; $display("FAIL hold_score cycle %0d got %0d want 12", k, bus.m_score); end
            checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready cycle %0d got %b want 0", k, bus.s_ready); end
        end
        bus.s_valid = 1'b0;
        release_decision();
    endtask

    task automatic test_reset_mid_frame();
        int a = 0; bit ok, all_ok = 1'b1;
        send_vec(10'h003, a, ok); all_ok &= ok;
        send_vec(10'h003, a, ok); all_ok &= ok;
        bus.s_valid = 1'b0;
        checks++; if (!all_ok) begin errors++; $display("FAIL midrst_timeout vectors not accepted"); end
        rst = 1'b1;
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready_in_rst got %b want 0", bus.s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_single_class("midrst", 0);
    endtask

    task automatic test_back_to_back();
        int a = 0, v = 0, h = 0; bit ok, all_ok = 1'b1;
        bus.m_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send_vec(10'h030, a, ok); all_ok &= ok;
        end
        bus.s_valid = 1'b0;
        wait_valid(v, ok); all_ok &= ok;
        checks++; if (bus.m_class !== 3'd2) begin errors++; $display("FAIL b2b_first_class got %0d want 2", bus.m_class); end
        bus.s_valid  = 1'b1;
        bus.s_scores = 10'h300;
        @(posedge clk); #1;
        h = cyc;
        checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_turnaround got m_valid %b s_ready %b want 0 1", bus.m_valid, bus.s_ready); end
        send_vec(10'h300, a, ok); all_ok &= ok;
        checks++; if (a - h !== 1) begin errors++; $display("FAIL b2b_first_accept got %0d cycles want 1", a - h); end
        for (int m = 1; m < 4; m++) begin
            send_vec(10'h300, a, ok); all_ok &= ok;
        end
        bus.s_valid = 1'b0;
        wait_valid(v, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL b2b_timeout handshake did not complete"); end
        checks++; if (bus.m_class !== 3'd4) begin errors++; $display("FAIL b2b_second_class got %0d want 4", bus.m_class); end
        checks++; if (bus.m_score !== 5'd12) begin errors++; $display("FAIL b2b_second_score got %0d want 12", bus.m_score); end
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_scores = '0;
        bus.m_ready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_single_class("basic", 0);
        test_tie();
        test_backpressure();
        test_single_class("gaps", 3);
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
